// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with parallel load and counted burst engine
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] d_out,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SLL = 3'b010;
  localparam logic [2:0] M_ROR = 3'b011;
  localparam logic [2:0] M_ROL = 3'b100;
  localparam logic [2:0] M_SRA = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, nxt_state;
  logic [CNT_W-1:0] remaining, nxt_remaining;
  logic [2:0]       mode_q, nxt_mode_q;
  logic [WIDTH-1:0] nxt_d;
  logic             nxt_sout_r, nxt_sout_l, nxt_done;
  logic             do_shift;
  logic [2:0]       shift_mode;

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      mode_q    <= '0;
      d_out     <= '0;
      sout_r    <= 1'b0;
      sout_l    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt_state;
      remaining <= nxt_remaining;
      mode_q    <= nxt_mode_q;
      d_out     <= nxt_d;
      sout_r    <= nxt_sout_r;
      sout_l    <= nxt_sout_l;
      done      <= nxt_done;
    end
  end

  // Control: decide whether this edge loads, shifts, or arms/ends a burst.
  always_comb begin
    nxt_state     = state;
    nxt_remaining = remaining;
    nxt_mode_q    = mode_q;
    nxt_done      = 1'b0;
    do_shift      = 1'b0;
    shift_mode    = mode;

    case (state)
      IDLE: begin
        if (load) begin
          // data path handles the load below
        end else if (start) begin
          if (count != '0) begin
            nxt_mode_q    = mode;
            nxt_remaining = count;
            nxt_state     = SHIFT;
          end else begin
            nxt_done = 1'b1;
          end
        end else if (en) begin
          do_shift   = 1'b1;
          shift_mode = mode;
        end
      end
      SHIFT: begin
        if (load) begin
          nxt_state     = IDLE;
          nxt_remaining = '0;
        end else begin
          do_shift      = 1'b1;
          shift_mode    = mode_q;
          nxt_remaining = remaining - CNT_ONE;
          if (remaining == CNT_ONE) begin
            nxt_state = IDLE;
            nxt_done  = 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Data path: parallel load wins, otherwise apply the selected shift.
  always_comb begin
    nxt_d      = d_out;
    nxt_sout_r = sout_r;
    nxt_sout_l = sout_l;

    if (load) begin
      nxt_d = p_in;
    end else if (do_shift) begin
      case (shift_mode)
        M_SRL: begin
          nxt_d      = {sin_r, d_out[WIDTH-1:1]};
          nxt_sout_r = d_out[0];
        end
        M_SLL: begin
          nxt_d      = {d_out[WIDTH-2:0], sin_l};
          nxt_sout_l = d_out[WIDTH-1];
        end
        M_ROR: begin
          nxt_d      = {d_out[0], d_out[WIDTH-1:1]};
          nxt_sout_r = d_out[0];
        end
        M_ROL: begin
          nxt_d      = {d_out[WIDTH-2:0], d_out[WIDTH-1]};
          nxt_sout_l = d_out[WIDTH-1];
        end
        M_SRA: begin
          nxt_d      = {d_out[WIDTH-1], d_out[WIDTH-1:1]};
          nxt_sout_r = d_out[0];
        end
        default: begin
          nxt_d = d_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] p_in;
  logic [2:0] mode;
  logic       sin_r, sin_l, en, start;
  logic [3:0] count;
  logic [7:0] d_out;
  logic       sout_r, sout_l, busy, done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .load(load), .p_in(p_in), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .en(en), .start(start), .count(count),
    .d_out(d_out), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; p_in = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; p_in = '0; mode = '0;
    sin_r = 1'b0; sin_l = 1'b0; en = 1'b0; start = 1'b0; count = '0;
    step(); step();
    check("rst_d", d_out, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); reset = 1'b1;
    step();

    // single-step logical right
    do_load(8'hB4);
    check("load_b4", d_out, 8'hB4);
    mode = 3'b001; sin_r = 1'b1; en = 1'b1;
    step();
    en = 1'b0;
    check("srl_d", d_out, 8'hDA);
    check("srl_sout_r", sout_r, 0);

    // hold mode 110 with en does nothing
    mode = 3'b110; en = 1'b1;
    step();
    en = 1'b0;
    check("hold110_d", d_out, 8'hDA);

    // rotate-left burst of 3
    do_load(8'h81);
    mode = 3'b100; start = 1'b1; count = 4'd3;
    step();
    start = 1'b0; mode = 3'b000;
    check("rol_e0_busy", busy, 1);
    check("rol_e0_d", d_out, 8'h81);
    step();
    check("rol_e1_d", d_out, 8'h03);
    check("rol_e1_sout_l", sout_l, 1);
    check("rol_e1_busy", busy, 1);
    step();
    check("rol_e2_d", d_out, 8'h06);
    check("rol_e2_done", done, 0);
    step();
    check("rol_e3_d", d_out, 8'h0C);
    check("rol_e3_busy", busy, 0);
    check("rol_e3_done", done, 1);
    check("rol_sout_l", sout_l, 0);
    step();
    check("rol_done_clr", done, 0);

    // arithmetic-right burst of 2
    do_load(8'h90);
    mode = 3'b101; start = 1'b1; count = 4'd2;
    step();
    start = 1'b0;
    step();
    check("sra_e1_d", d_out, 8'hC8);
    step();
    check("sra_e2_d", d_out, 8'hE4);
    check("sra_sout_r", sout_r, 0);
    check("sra_done", done, 1);
    step();
    check("sra_done_clr", done, 0);

    // load aborts a left burst
    do_load(8'h0F);
    mode = 3'b010; sin_l = 1'b0; start = 1'b1; count = 4'd5;
    step();
    start = 1'b0;
    step(); step();
    check("abort_pre_d", d_out, 8'h3C);
    check("abort_pre_busy", busy, 1);
    load = 1'b1; p_in = 8'hA5;
    step();
    load = 1'b0;
    check("abort_d", d_out, 8'hA5);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    step();
    check("abort_done2", done, 0);
    check("abort_d2", d_out, 8'hA5);

    // start with count=0
    mode = 3'b001; start = 1'b1; count = 4'd0;
    step();
    start = 1'b0;
    check("cnt0_done", done, 1);
    check("cnt0_busy", busy, 0);
    check("cnt0_d", d_out, 8'hA5);
    step();
    check("cnt0_done_clr", done, 0);

    // en and mode changes ignored during burst (rotate right latched)
    do_load(8'h80);
    mode = 3'b011; start = 1'b1; count = 4'd2;
    step();
    start = 1'b0; en = 1'b1; mode = 3'b010; sin_l = 1'b1;
    step();
    check("ign_e1_d", d_out, 8'h40);
    mode = 3'b100;
    step();
    en = 1'b0; mode = 3'b000; sin_l = 1'b0;
    check("ign_e2_d", d_out, 8'h20);
    check("ign_done", done, 1);

    // start held through completion re-triggers
    do_load(8'h01);
    mode = 3'b011; start = 1'b1; count = 4'd1;
    step();
    check("retrig_e0_busy", busy, 1);
    step();
    check("retrig_e1_d", d_out, 8'h80);
    check("retrig_e1_done", done, 1);
    check("retrig_e1_busy", busy, 0);
    check("retrig_sout_r", sout_r, 1);
    step();
    start = 1'b0;
    check("retrig_e2_busy", busy, 1);
    check("retrig_e2_done", done, 0);
    step();
    check("retrig_e3_d", d_out, 8'h40);
    check("retrig_e3_done", done, 1);

    // async reset mid-burst
    do_load(8'h3C);
    mode = 3'b001; sin_r = 1'b1; start = 1'b1; count = 4'd5;
    step();
    start = 1'b0;
    step();
    check("mid_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_d", d_out, 8'h00);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sout_r", sout_r, 0);
    check("arst_sout_l", sout_l, 0);
    step();
    check("arst_hold_d", d_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
